// File: rtl/arbitro_bus2.sv
// Round-robin arbiter for a shared 2-input bus mux with a hold limit.
// Drives the mux select and registers the selected word with a valid strobe.
module arbitro_bus2 #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             sel,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } state_e;

    localparam bit         HOLD_EN   = (MAX_HOLD != 0);
    localparam logic [7:0] HOLD_LAST = HOLD_EN ? 8'(MAX_HOLD - 1) : 8'd0;

    state_e           state_q, state_d;
    logic [7:0]       hold_cnt_q, hold_cnt_d;
    logic             last_b_q, last_b_d;
    logic             sel_q, sel_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;

    logic             own_req;
    logic             other_req;
    logic             hold_hit;

    always_comb begin
        own_req   = 1'b0;
        other_req = 1'b0;
        unique case (state_q)
            GRANT_A: begin
                own_req   = req_a;
                other_req = req_b;
            end
            GRANT_B: begin
                own_req   = req_b;
                other_req = req_a;
            end
            default: begin
                own_req   = 1'b0;
                other_req = 1'b0;
            end
        endcase
        hold_hit = HOLD_EN && other_req && (hold_cnt_q == HOLD_LAST);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req_a && req_b) begin
                    state_d = last_b_q ? GRANT_A : GRANT_B;
                end else if (req_a) begin
                    state_d = GRANT_A;
                end else if (req_b) begin
                    state_d = GRANT_B;
                end
            end
            GRANT_A: begin
                if (!req_a) begin
                    state_d = req_b ? GRANT_B : IDLE;
                end else if (hold_hit) begin
                    state_d = GRANT_B;
                end
            end
            GRANT_B: begin
                if (!req_b) begin
                    state_d = req_a ? GRANT_A : IDLE;
                end else if (hold_hit) begin
                    state_d = GRANT_A;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Counts cycles the current owner has kept the bus while the other side waits.
    always_comb begin
        hold_cnt_d = 8'd0;
        if (state_d == state_q && other_req) begin
            hold_cnt_d = (hold_cnt_q == 8'hFF) ? hold_cnt_q : hold_cnt_q + 8'd1;
        end
    end

    always_comb begin
        last_b_d = last_b_q;
        sel_d    = sel_q;
        if (state_d == GRANT_A) begin
            sel_d = 1'b0;
            if (state_q != GRANT_A) last_b_d = 1'b0;
        end else if (state_d == GRANT_B) begin
            sel_d = 1'b1;
            if (state_q != GRANT_B) last_b_d = 1'b1;
        end
    end

    always_comb begin
        valid_d = own_req;
        data_d  = data_q;
        if (own_req) begin
            data_d = (state_q == GRANT_B) ? data_b : data_a;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            hold_cnt_q <= 8'd0;
            last_b_q   <= 1'b1;
            sel_q      <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            last_b_q   <= last_b_d;
            sel_q      <= sel_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
        end
    end

    assign gnt_a   = (state_q == GRANT_A);
    assign gnt_b   = (state_q == GRANT_B);
    assign busy    = gnt_a | gnt_b;
    assign sel     = sel_q;
    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: tb/tb_arbitro_bus2.sv
// Bench for arbitro_bus2: three hold limits (8, 0, 1) share one stimulus
// and are checked every cycle against a per-cycle ownership model.
module tb_arbitro_bus2;

    localparam int N = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ra, rb;
    logic [31:0] da, db;

    logic        ga [N];
    logic        gb [N];
    logic        sl [N];
    logic        vo [N];
    logic        by [N];
    logic [31:0] dq [N];

    int vectors = 0;
    int miscompares = 0;

    // Model: owner 0=none 1=A 2=B; w = waited cycles in current grant.
    int          own  [N];
    int          last [N];
    int          w    [N];
    bit          msel [N];
    bit          mval [N];
    logic [31:0] mdat [N];

    always #5 clk = ~clk;

    arbitro_bus2 #(.WIDTH(32), .MAX_HOLD(8)) u8 (
        .clk(clk), .rst_n(rst_n), .req_a(ra), .req_b(rb),
        .data_a(da), .data_b(db), .gnt_a(ga[0]), .gnt_b(gb[0]),
        .sel(sl[0]), .data_o(dq[0]), .valid_o(vo[0]), .busy(by[0])
    );

    arbitro_bus2 #(.WIDTH(32), .MAX_HOLD(0)) u0 (
        .clk(clk), .rst_n(rst_n), .req_a(ra), .req_b(rb),
        .data_a(da), .data_b(db), .gnt_a(ga[1]), .gnt_b(gb[1]),
        .sel(sl[1]), .data_o(dq[1]), .valid_o(vo[1]), .busy(by[1])
    );

    arbitro_bus2 #(.WIDTH(32), .MAX_HOLD(1)) u1 (
        .clk(clk), .rst_n(rst_n), .req_a(ra), .req_b(rb),
        .data_a(da), .data_b(db), .gnt_a(ga[2]), .gnt_b(gb[2]),
        .sel(sl[2]), .data_o(dq[2]), .valid_o(vo[2]), .busy(by[2])
    );

    function automatic int mh(int i);
        case (i)
            0:       return 8;
            1:       return 0;
            default: return 1;
        endcase
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            own[i]  = 0;
            last[i] = 2;
            w[i]    = 0;
            msel[i] = 1'b0;
            mval[i] = 1'b0;
            mdat[i] = '0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < N; i++) begin
            bit mine, other;
            int nown, wn;
            mine  = (own[i] == 1) ? ra : (own[i] == 2) ? rb : 1'b0;
            other = (own[i] == 1) ? rb : (own[i] == 2) ? ra : 1'b0;
            mval[i] = mine;
            if (mine) mdat[i] = (own[i] == 1) ? da : db;
            wn = 0;
            if (own[i] == 0) begin
                if (ra && rb) nown = (last[i] == 1) ? 2 : 1;
                else nown = ra ? 1 : rb ? 2 : 0;
            end else if (!mine) begin
                nown = other ? 3 - own[i] : 0;
            end else begin
                wn = other ? w[i] + 1 : 0;
                if (mh(i) != 0 && other && wn >= mh(i)) nown = 3 - own[i];
                else nown = own[i];
            end
            w[i] = (nown != own[i]) ? 0 : wn;
            if (nown != 0 && nown != own[i]) last[i] = nown;
            if (nown != 0) msel[i] = (nown == 2);
            own[i] = nown;
        end
    endtask

    task automatic check_all(string ph);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("%s.gnt_a[%0d]", ph, i), 32'(ga[i]), 32'(own[i] == 1));
            chk($sformatf("%s.gnt_b[%0d]", ph, i), 32'(gb[i]), 32'(own[i] == 2));
            chk($sformatf("%s.busy[%0d]", ph, i), 32'(by[i]), 32'(own[i] != 0));
            chk($sformatf("%s.sel[%0d]", ph, i), 32'(sl[i]), 32'(msel[i]));
            chk($sformatf("%s.valid[%0d]", ph, i), 32'(vo[i]), 32'(mval[i]));
            chk($sformatf("%s.data[%0d]", ph, i), dq[i], mdat[i]);
        end
    endtask

    task automatic step(string ph);
        model_step();
        @(posedge clk);
        #1;
        check_all(ph);
    endtask

    // Called 1 time unit after a rising edge; finishes before the next one.
    task automatic do_reset(string ph);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all(ph);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        ra = 1'b0;
        rb = 1'b0;
        da = '0;
        db = '0;
        model_reset();
        #2;
        check_all("rst");
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        ra = 1'b1; da = 32'd3;
        step("a_only");
        step("a_only");
        step("a_only");
        ra = 1'b0;
        step("a_drop");
        step("a_idle");

        do_reset("rst2");
        ra = 1'b1; rb = 1'b1; da = 32'd3; db = 32'd5;
        step("tie");
        step("tie");
        step("tie");
        ra = 1'b0;
        step("handover");
        step("handover");
        rb = 1'b0;
        step("drain");
        step("drain");

        ra = 1'b1; rb = 1'b1;
        for (int k = 0; k < 40; k++) begin
            da = $urandom; db = $urandom;
            step("both");
        end
        ra = 1'b0; rb = 1'b0;
        step("both_end");
        step("both_end");

        rb = 1'b1;
        for (int k = 0; k < 20; k++) begin
            db = $urandom;
            step("b_only");
        end
        ra = 1'b1;
        step("b_mid");
        do_reset("rst_mid");
        step("after_rst");
        step("after_rst");
        ra = 1'b0; rb = 1'b0;
        step("idle");

        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(7) == 0) ra = ~ra;
            if ($urandom_range(7) == 0) rb = ~rb;
            da = $urandom;
            db = $urandom;
            if ($urandom_range(99) == 0) do_reset("rnd_rst");
            step("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
